// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage: widths, reset PC, NOP encoding and FSM states.
package riscv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
    parameter int XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/fetch_hold_reg.sv
// One-entry hold slot {pc, instr} that parks a response arriving while the output register is stalled.
module fetch_hold_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, feeds IF/ID.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters.
//   state | meaning
//   FETCH | request pc_q (suppressed while redirecting)
//   WAIT  | request accepted, waiting for its response (dropped if drop_q)
//   HOLD  | response parked in the hold slot until the stall releases
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    fetch_stage_if.master       imem,
    output logic                if_valid_o,
    output logic [XLEN-1:0]     if_pc_o,
    output logic [31:0]         if_instr_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt_o,
    output logic [31:0]         perf_bubble_cnt_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic            r_valid_q, r_valid_d;
    logic [XLEN-1:0] r_pc_q, r_pc_d;
    logic [31:0]     r_instr_q, r_instr_d;

    logic            req_fire;
    logic            r_load;
    logic [XLEN-1:0] r_load_pc;
    logic [31:0]     r_load_instr;
    logic            hold_load, hold_clear, hold_valid;
    logic [XLEN-1:0] hold_pc;
    logic [31:0]     hold_instr;
    logic            unused_hold_valid;
    logic            unused_redirect_lsb;

    // Redirect targets are forced word aligned, so the low bits never matter.
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
    assign unused_hold_valid   = hold_valid;

    assign imem.req_valid = rst_n && (state_q == FETCH) && !redirect_i;
    assign imem.req_addr  = pc_q;
    assign req_fire       = imem.req_valid && imem.req_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        r_load       = 1'b0;
        r_load_pc    = req_pc_q;
        r_load_instr = imem.rsp_data;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        case (state_q)
            FETCH: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    drop_d = 1'b0;
                    if (redirect_i || drop_q) begin
                        state_d = FETCH;
                    end else if (!stall_i || !r_valid_q) begin
                        r_load  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_d = FETCH;
                end else if (!stall_i) begin
                    r_load       = 1'b1;
                    r_load_pc    = hold_pc;
                    r_load_instr = hold_instr;
                    hold_clear   = 1'b1;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
            hold_clear = 1'b1;
        end
    end

    // Output register: redirect squashes, a load wins over consumption, stall freezes.
    always_comb begin
        r_valid_d = r_valid_q;
        r_pc_d    = r_pc_q;
        r_instr_d = r_instr_q;
        if (redirect_i) begin
            r_valid_d = 1'b0;
            r_instr_d = NOP_INSTR;
        end else if (r_load) begin
            r_valid_d = 1'b1;
            r_pc_d    = r_load_pc;
            r_instr_d = r_load_instr;
        end else if (!stall_i) begin
            r_valid_d = 1'b0;
            r_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            drop_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_pc_q    <= '0;
            r_instr_q <= NOP_INSTR;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            drop_q    <= drop_d;
            r_valid_q <= r_valid_d;
            r_pc_q    <= r_pc_d;
            r_instr_q <= r_instr_d;
        end
    end

    fetch_hold_reg #(
        .XLEN (XLEN)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .pc_i    (req_pc_q),
        .instr_i (imem.rsp_data),
        .valid_o (hold_valid),
        .pc_o    (hold_pc),
        .instr_o (hold_instr)
    );

    assign if_valid_o = r_valid_q;
    assign if_pc_o    = r_pc_q;
    assign if_instr_o = r_instr_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (r_load && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (!r_valid_q && !stall_i && (perf_bubble_q != 32'hFFFF_FFFF)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch_cnt_o  = perf_fetch_q;
    assign perf_bubble_cnt_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stall/redirect/ready traffic
// checked against an in-order instruction-stream model and a simple latency-driven memory.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int          XLEN = 32;
    localparam logic [31:0] KEY  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_bubble_cnt_o;
    int unsigned m_fetch, m_bubble;
    bit          prev_valid, prev_stall;
`endif

    fetch_stage_if #(.XLEN(XLEN)) imem ();

    fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o  (perf_fetch_cnt_o),
        .perf_bubble_cnt_o (perf_bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model: one outstanding request, response after mem_cnt cycles
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          next_lat = 1;

    // stream model: next address to be requested and next PC to be delivered to IF/ID
    logic [31:0] exp_req, exp_pc;
    int          delivered;

    logic        obs_valid, obs_req;
    logic [31:0] obs_pc, obs_instr, obs_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = '0;
        mem_pend = 1'b0;
        #1;
        chk("rst_valid", if_valid_o, 0);
        chk("rst_pc", if_pc_o, 0);
        chk("rst_instr", if_instr_o, NOP_INSTR);
        chk("rst_req_valid", imem.req_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_req = 32'h0;
        exp_pc  = 32'h0;
`ifdef FETCH_PERF_EN
        m_fetch = 0;
        m_bubble = 0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
`endif
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, sample/check at posedge+2, end at next posedge+1.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        stall_i = st;
        redirect_i = rd;
        redirect_pc_i = rpc;
        imem.req_ready = rdy;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data = mem_addr ^ KEY;
                mem_pend = 1'b0;
            end
        end
        #1;
        obs_valid = if_valid_o;
        obs_pc    = if_pc_o;
        obs_instr = if_instr_o;
        obs_req   = imem.req_valid;
        obs_addr  = imem.req_addr;
`ifdef FETCH_PERF_EN
        if (obs_valid && (!prev_valid || !prev_stall)) m_fetch++;
        chk("perf_fetch", perf_fetch_cnt_o, m_fetch);
        chk("perf_bubble", perf_bubble_cnt_o, m_bubble);
        if (!obs_valid && !st) m_bubble++;
        prev_valid = obs_valid;
        prev_stall = st;
`endif
        if (rd) begin
            chk("no_req_on_redirect", obs_req, 0);
            exp_req = {rpc[31:2], 2'b00};
            exp_pc  = {rpc[31:2], 2'b00};
        end else begin
            if (obs_req && rdy) begin
                chk("req_addr", obs_addr, exp_req);
                exp_req += 32'd4;
            end
            if (obs_valid && !st) begin
                chk("deliver_pc", obs_pc, exp_pc);
                chk("deliver_instr", obs_instr, exp_pc ^ KEY);
                exp_pc += 32'd4;
                delivered++;
            end
        end
        if (!obs_valid) chk("nop_when_empty", obs_instr, NOP_INSTR);
        if (obs_req && rdy) begin
            chk("one_in_flight", mem_pend, 0);
            mem_pend = 1'b1;
            mem_cnt  = next_lat;
            mem_addr = obs_addr;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int start_cnt;
        @(posedge clk); #1;

        // back-to-back with a 1-cycle memory
        do_reset();
        next_lat = 1;
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, 1);
            chk("t1_valid", obs_valid, (k >= 2) && (k % 2 == 0));
            if (k >= 2 && k % 2 == 0) chk("t1_pc", obs_pc, (k - 2) * 2);
        end

        // stall with R full while a response arrives: response parks in the hold slot
        do_reset();
        for (int k = 0; k < 11; k++) begin
            step((k >= 4) && (k <= 7), 0, 0, 1);
            if (k >= 4 && k <= 7) begin
                chk("t2_hold_valid", obs_valid, 1);
                chk("t2_hold_pc", obs_pc, 32'h4);
            end
            if (k == 6 || k == 7) chk("t2_no_req_in_hold", obs_req, 0);
            if (k == 9) begin
                chk("t2_slot_valid", obs_valid, 1);
                chk("t2_slot_pc", obs_pc, 32'h8);
            end
            if (k == 10) chk("t2_no_dup", obs_valid, 0);
        end

        // redirect while waiting, response two cycles later is dropped
        do_reset();
        next_lat = 3;
        step(0, 0, 0, 1);
        next_lat = 1;
        step(0, 1, 32'h100, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t3_drop_valid", obs_valid, 0);
        step(0, 0, 0, 1);
        chk("t3_req_valid", obs_req, 1);
        chk("t3_req_addr", obs_addr, 32'h100);
        chk("t3_still_empty", obs_valid, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t3_valid", obs_valid, 1);
        chk("t3_pc", obs_pc, 32'h100);

        // redirect in the same cycle as a response, unaligned target
        do_reset();
        step(0, 0, 0, 1);
        step(0, 1, 32'h203, 1);
        step(0, 0, 0, 1);
        chk("t4_req_valid", obs_req, 1);
        chk("t4_req_addr", obs_addr, 32'h200);
        chk("t4_discarded", obs_valid, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t4_valid", obs_valid, 1);
        chk("t4_pc", obs_pc, 32'h200);

        // memory not ready for 3 cycles: request held with a stable address
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk("t5_req_held", obs_req, 1);
            chk("t5_addr_stable", obs_addr, 32'h0);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t5_next_req", obs_req, 1);
        chk("t5_next_addr", obs_addr, 32'h4);

        // PC wrap at the top of the address space
        do_reset();
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        chk("t6_top_addr", obs_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t6_wrap_req", obs_req, 1);
        chk("t6_wrap_addr", obs_addr, 32'h0);
        chk("t6_top_pc", obs_pc, 32'hFFFF_FFFC);

        // random traffic
        do_reset();
        start_cnt = delivered;
        for (int n = 0; n < 3000; n++) begin
            next_lat = $urandom_range(1, 4);
            step(($urandom % 4) == 0, ($urandom % 25) == 0, $urandom, ($urandom % 10) < 7);
        end
        chk("random_progress", (delivered - start_cnt) >= 100, 1);

        // async reset in the middle of traffic, then restart from RESET_PC
        next_lat = 2;
        step(0, 0, 0, 1);
        do_reset();
        next_lat = 1;
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
        chk("post_reset_pc", exp_pc, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage: owns the PC and issues instruction-memory requests.
- Delivers {valid, pc, instr} to the IF/ID pipe register, which reads them whenever stall is low.
- Honours the same stall as the IF/ID pipe register, and a redirect from EX on branches and jumps.
- At most one memory request in flight; a one-entry hold slot absorbs a response that arrives during a stall.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hazard-unit stall; same signal that drives the IF/ID stage stall.
- redirect_i  in  1  taken branch/jump from EX; also asserts IF/ID flush externally.
- redirect_pc_i  in  XLEN  redirect target.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_req_addr_o  out  XLEN  fetch address, word aligned.
- imem_rsp_valid_i  in  1  response valid; exactly one per accepted request, at least 1 cycle later.
- imem_rsp_data_i  in  32  instruction word.
- if_valid_o  out  1  output register holds a real instruction.
- if_pc_o  out  XLEN  PC of if_instr_o.
- if_instr_o  out  32  instruction; NOP (32'h0000_0013) when not valid.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=FETCH, drop_q=0, hold slot empty.
  - Outputs: if_valid_o=0, if_pc_o=0, if_instr_o=NOP, imem_req_valid_o=0.
- Output register R drives the if_* outputs. Hold slot S stores {pc, instr}.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req_valid_o = !redirect_i; imem_req_addr_o = pc_q.
  - On valid&ready: req_pc_q <= pc_q, pc_q <= pc_q+4 (mod 2^XLEN, wrap silently), go to WAIT.
- WAIT: on imem_rsp_valid_i with drop_q=0:
  - If !stall_i or R empty: R <= {1, req_pc_q, data}, go to FETCH.
  - Else: S <= {req_pc_q, data}, go to HOLD.
- WAIT with drop_q=1: the response is discarded, drop_q <= 0, go to FETCH.
- HOLD:
  - No requests issued.
  - On !stall_i: R <= {1, S}, go to FETCH.
- Consumption: when !stall_i and nothing loads R this cycle, R.valid <= 0 and R.instr <= NOP.
- While stall_i=1, R holds unchanged.
- Redirect (priority over stall and over every state):
  - pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00}; R.valid <= 0; S cleared.
  - In WAIT without a same-cycle response: drop_q <= 1 and stay in WAIT.
  - In WAIT with a same-cycle response: the response is discarded, go to FETCH.
  - In HOLD: go to FETCH.
  - In FETCH: no request issues that cycle.
  - Next request address = redirect target.
- Latency: request accepted at cycle N, response at N+k, then if_valid_o=1 at N+k+1.
- Back-to-back throughput: 1 instruction every 2 cycles with a single-cycle memory.
- Simultaneous stall and response with R full: the response goes to S; nothing is lost or duplicated.
- rst_n asserted mid-request: all state cleared. Memory is reset by the same rst_n, so no stale response returns.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt_o[31:0] and perf_bubble_cnt_o[31:0].
  - perf_fetch_cnt_o increments on each instruction loaded into R.
  - perf_bubble_cnt_o increments on each cycle with if_valid_o=0 and stall_i=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN default.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
  - fetch_state_t enum {FETCH, WAIT, HOLD}.
- One sub-module, fetch_hold_reg: the S slot (load, clear, valid, pc, instr), async active-low reset.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr^32'hA5A5_A5A5 → if_pc_o sequence 0x0, 0x4, 0x8; if_valid_o pulses 1 every other cycle.
- stall_i=1 for 4 cycles while a response arrives with R full → R holds pc 0x4; S captures pc 0x8; after release pc 0x8 appears next cycle with no duplicate.
- redirect_i to 0x100 while in WAIT, response arrives 2 cycles later → that response is dropped; next request addr=0x100; if_pc_o=0x100.
- redirect_i to 0x203 in the same cycle as a response → response discarded; imem_req_addr_o=0x200.
- imem_req_ready_i=0 for 3 cycles → imem_req_valid_o stays 1 with a stable address; pc_q does not advance.
- PC 0xFFFF_FFFC fetched → next request address 0x0000_0000; with FETCH_PERF_EN, perf_fetch_cnt_o counts exactly the delivered instructions.
